// File: rtl/oled_mode_selector_pkg.sv
// Shared OLED constants plus the one-hot decode helper used by the mode selector.
package oled_mode_selector_pkg;

    localparam int unsigned PIX_W     = 16;
    localparam int unsigned PIX_IDX_W = 13;
    localparam int unsigned OLED_W    = 96;
    localparam int unsigned OLED_H    = 64;

    localparam logic [PIX_W-1:0] COLOR_BLACK   = 16'h0000;
    localparam logic [PIX_W-1:0] COLOR_RED     = 16'hF800;
    localparam logic [PIX_W-1:0] COLOR_GREEN   = 16'h07E0;
    localparam logic [PIX_W-1:0] COLOR_MAGENTA = 16'hF81F;

    // Widest supported switch bank; narrower banks are zero-extended into it.
    localparam int unsigned MAX_CH = 8;

    typedef logic [MAX_CH-1:0] sw_vec_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } sel_t;

    // valid when exactly one bit is set; idx is forced to 0 otherwise.
    function automatic sel_t decode_one_hot(sw_vec_t v);
        sel_t        s;
        int unsigned ones;
        s    = '0;
        ones = 0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (v[i]) begin
                ones  = ones + 1;
                s.idx = 3'(i);
            end
        end
        s.valid = (ones == 1);
        if (!s.valid) begin
            s.idx = '0;
        end
        return s;
    endfunction

endpackage

// File: rtl/oled_mode_selector_if.sv
// Switch, frame and pixel signals between the task pixel sources and the mode selector.
interface oled_mode_selector_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned PIX_W  = 16
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]       sw;
    logic                    frame_begin;
    logic [NUM_CH*PIX_W-1:0] ch_pixel;
    logic [PIX_W-1:0]        pixel_data;
    logic [NUM_CH-1:0]       ch_enable;
    logic                    ch_valid;
    logic [CH_W-1:0]         active_ch;
    logic                    mode_change;

    modport master (
        output sw,
        output frame_begin,
        output ch_pixel,
        input  pixel_data,
        input  ch_enable,
        input  ch_valid,
        input  active_ch,
        input  mode_change
    );

    modport slave (
        input  sw,
        input  frame_begin,
        input  ch_pixel,
        output pixel_data,
        output ch_enable,
        output ch_valid,
        output active_ch,
        output mode_change
    );

endinterface

// File: rtl/oled_mode_selector_switch_debouncer.sv
// Two-flop synchroniser and stability counter; a switch value that holds for
// STABLE_CYCLES cycles is copied into the registered pending output.
module switch_debouncer #(
    parameter int unsigned W             = 4,
    parameter int unsigned STABLE_CYCLES = 62500
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] sw,
    output logic [W-1:0] pending
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [W-1:0]     sync1_q;
    logic [W-1:0]     sync2_q;
    logic [W-1:0]     prev_q;
    logic [W-1:0]     pending_q, pending_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             equal;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            cnt_q     <= '0;
            pending_q <= '0;
        end else begin
            sync1_q   <= sw;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    // cnt_q counts equal cycles minus one, so the copy lands STABLE_CYCLES+3 clk after an edge.
    always_comb begin
        equal     = (sync2_q == prev_q);
        cnt_d     = cnt_q;
        pending_d = pending_q;
        if (!equal) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            pending_d = sync2_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/oled_mode_selector.sv
// Frame-aligned task selector for the OLED pixel_data input: commits debounced
// switch modes at frame_begin, blanks after a change and decodes the one-hot mode.
module oled_mode_selector #(
    parameter int unsigned       NUM_CH        = 4,
    parameter int unsigned       PIX_W         = 16,
    parameter logic [PIX_W-1:0]  DEFAULT_COLOR = 16'hF81F,
    parameter int unsigned       BLANK_FRAMES  = 1,
    parameter int unsigned       STABLE_CYCLES = 62500
) (
    input logic                clk,
    input logic                reset,
    oled_mode_selector_if.slave bus
);

    import oled_mode_selector_pkg::*;

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [3:0] BLANK_INIT = 4'(BLANK_FRAMES);

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] active_q, active_d;
    logic [3:0]        blank_q, blank_d;
    logic              armed_q, armed_d;
    logic              mode_change_q, mode_change_d;
    logic              ch_valid_q, ch_valid_d;
    logic [NUM_CH-1:0] ch_enable_q, ch_enable_d;
    logic [CH_W-1:0]   active_ch_q, active_ch_d;
    logic [PIX_W-1:0]  pixel_q, pixel_d;
    logic              commit;
    sel_t              sel;

    switch_debouncer #(
        .W             (NUM_CH),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_debouncer (
        .clk     (clk),
        .reset   (reset),
        .sw      (bus.sw),
        .pending (pending)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q      <= '0;
            blank_q       <= '0;
            armed_q       <= 1'b0;
            mode_change_q <= 1'b0;
            ch_valid_q    <= 1'b0;
            ch_enable_q   <= '0;
            active_ch_q   <= '0;
            pixel_q       <= '0;
        end else begin
            active_q      <= active_d;
            blank_q       <= blank_d;
            armed_q       <= armed_d;
            mode_change_q <= mode_change_d;
            ch_valid_q    <= ch_valid_d;
            ch_enable_q   <= ch_enable_d;
            active_ch_q   <= active_ch_d;
            pixel_q       <= pixel_d;
        end
    end

    // Commit and blank counter; a commit always reloads the blank count.
    always_comb begin
        commit        = bus.frame_begin && (pending != active_q);
        active_d      = active_q;
        blank_d       = blank_q;
        armed_d       = armed_q;
        mode_change_d = 1'b0;
        if (commit) begin
            active_d      = pending;
            blank_d       = BLANK_INIT;
            armed_d       = 1'b1;
            mode_change_d = 1'b1;
        end else if (bus.frame_begin && (blank_q != '0)) begin
            blank_d = blank_q - 4'd1;
        end
    end

    always_comb begin
        sel         = decode_one_hot(sw_vec_t'(active_q));
        ch_valid_d  = sel.valid;
        active_ch_d = CH_W'(sel.idx);
        ch_enable_d = sel.valid ? active_q : '0;
    end

    // Until the first commit after reset nothing has been selected, so stay black.
    always_comb begin
        if (!armed_q || (blank_q != '0)) begin
            pixel_d = '0;
        end else if (ch_valid_q) begin
            pixel_d = bus.ch_pixel[active_ch_q*PIX_W +: PIX_W];
        end else begin
            pixel_d = DEFAULT_COLOR;
        end
    end

    assign bus.pixel_data  = pixel_q;
    assign bus.ch_enable   = ch_enable_q;
    assign bus.ch_valid    = ch_valid_q;
    assign bus.active_ch   = active_ch_q;
    assign bus.mode_change = mode_change_q;

endmodule

// File: tb/tb_oled_mode_selector.sv
// Directed bench for oled_mode_selector: vector table over frames plus hand
// sequences for blanking reload, glitches, commit latency and mid-frame reset.
module tb_oled_mode_selector;

    localparam int unsigned FRAME_LEN = 100;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   mc;
    int   mc_total;

    always #5 clk = ~clk;

    oled_mode_selector_if #(.NUM_CH(4), .PIX_W(16)) bus ();

    oled_mode_selector #(
        .NUM_CH        (4),
        .PIX_W         (16),
        .DEFAULT_COLOR (16'hF81F),
        .BLANK_FRAMES  (1),
        .STABLE_CYCLES (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  sw;
        int          frames;
        int          exp_mc;
        logic [15:0] exp_pix;
        logic [3:0]  exp_en;
        logic        exp_valid;
        logic [1:0]  exp_ach;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [15:0] pix, input logic [3:0] en,
                                 input logic valid, input logic [1:0] ach);
        check({tag, ".pixel"}, 32'(bus.pixel_data), 32'(pix));
        check({tag, ".enable"}, 32'(bus.ch_enable), 32'(en));
        check({tag, ".valid"}, 32'(bus.ch_valid), 32'(valid));
        check({tag, ".active_ch"}, 32'(bus.active_ch), 32'(ach));
    endtask

    // One frame of FRAME_LEN cycles with frame_begin in the first; optionally moves sw
    // to alt_sw at cycle alt_start for alt_len cycles (alt_len >= FRAME_LEN: permanent).
    task automatic run_frame(input logic [3:0] alt_sw, input int alt_start, input int alt_len,
                             output int mc_cnt);
        logic [3:0] base;
        base   = bus.sw;
        mc_cnt = 0;
        for (int c = 0; c < int'(FRAME_LEN); c++) begin
            @(negedge clk);
            if (bus.mode_change) mc_cnt++;
            bus.frame_begin = (c == 0);
            if (alt_len > 0 && c == alt_start) bus.sw = alt_sw;
            if (alt_len > 0 && alt_len < int'(FRAME_LEN) && c == alt_start + alt_len) bus.sw = base;
        end
    endtask

    initial begin
        vecs[0] = '{4'b0000, 3, 0, 16'h0000, 4'b0000, 1'b0, 2'd0};
        vecs[1] = '{4'b0010, 3, 1, 16'h2222, 4'b0010, 1'b1, 2'd1};
        vecs[2] = '{4'b0001, 3, 1, 16'h1111, 4'b0001, 1'b1, 2'd0};
        vecs[3] = '{4'b0100, 3, 1, 16'h3333, 4'b0100, 1'b1, 2'd2};
        vecs[4] = '{4'b1000, 3, 1, 16'h4444, 4'b1000, 1'b1, 2'd3};
        vecs[5] = '{4'b0011, 3, 1, 16'hF81F, 4'b0000, 1'b0, 2'd0};
        vecs[6] = '{4'b0000, 3, 1, 16'hF81F, 4'b0000, 1'b0, 2'd0};
        vecs[7] = '{4'b1000, 3, 1, 16'h4444, 4'b1000, 1'b1, 2'd3};
        vecs[8] = '{4'b1000, 3, 0, 16'h4444, 4'b1000, 1'b1, 2'd3};

        bus.sw          = 4'b0000;
        bus.frame_begin = 1'b0;
        bus.ch_pixel    = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        reset           = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_outputs("reset", 16'h0000, 4'b0000, 1'b0, 2'd0);
        check("reset.mode_change", 32'(bus.mode_change), 32'd0);

        for (int i = 0; i < 9; i++) begin
            bus.sw   = vecs[i].sw;
            mc_total = 0;
            for (int f = 0; f < vecs[i].frames; f++) begin
                run_frame(4'b0000, 0, 0, mc);
                mc_total += mc;
            end
            check($sformatf("vec%0d.mode_change_count", i), 32'(mc_total), 32'(vecs[i].exp_mc));
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_pix, vecs[i].exp_en,
                          vecs[i].exp_valid, vecs[i].exp_ach);
        end

        // Change accepted during the blank frame: second commit reloads blanking.
        bus.sw = 4'b0010;
        run_frame(4'b0000, 0, 0, mc);
        check("blank.f1.mc", 32'(mc), 32'd0);
        check("blank.f1.pixel", 32'(bus.pixel_data), 32'h4444);
        run_frame(4'b1000, 5, 100, mc);
        check("blank.f2.mc", 32'(mc), 32'd1);
        check("blank.f2.pixel", 32'(bus.pixel_data), 32'h0000);
        check("blank.f2.enable", 32'(bus.ch_enable), 32'b0010);
        run_frame(4'b0000, 0, 0, mc);
        check("blank.f3.mc", 32'(mc), 32'd1);
        check("blank.f3.pixel", 32'(bus.pixel_data), 32'h0000);
        check("blank.f3.enable", 32'(bus.ch_enable), 32'b1000);
        run_frame(4'b0000, 0, 0, mc);
        check("blank.f4.mc", 32'(mc), 32'd0);
        check("blank.f4.pixel", 32'(bus.pixel_data), 32'h4444);

        // Short glitch, then a debounced excursion that returns before frame_begin.
        mc_total = 0;
        run_frame(4'b0010, 10, 5, mc);
        mc_total += mc;
        run_frame(4'b0000, 0, 0, mc);
        mc_total += mc;
        check("glitch.mc", 32'(mc_total), 32'd0);
        check("glitch.pixel", 32'(bus.pixel_data), 32'h4444);
        mc_total = 0;
        run_frame(4'b0001, 5, 30, mc);
        mc_total += mc;
        run_frame(4'b0000, 0, 0, mc);
        mc_total += mc;
        check("return.mc", 32'(mc_total), 32'd0);
        check_outputs("return", 16'h4444, 4'b1000, 1'b1, 2'd3);

        // Pending lands on the 11th edge after the sw change; a frame_begin on that
        // same edge must not commit, the one on the following edge must.
        bus.sw = 4'b0001;
        repeat (10) @(negedge clk);
        bus.frame_begin = 1'b1;
        @(negedge clk);
        check("latency.same_edge_mc", 32'(bus.mode_change), 32'd0);
        @(negedge clk);
        check("latency.next_edge_mc", 32'(bus.mode_change), 32'd1);
        bus.frame_begin = 1'b0;
        @(negedge clk);
        check("latency.pulse_width", 32'(bus.mode_change), 32'd0);
        check_outputs("latency", 16'h0000, 4'b0001, 1'b1, 2'd0);
        run_frame(4'b0000, 0, 0, mc);
        check("latency.after.mc", 32'(mc), 32'd0);
        check("latency.after.pixel", 32'(bus.pixel_data), 32'h1111);

        // Reset in the middle of a frame.
        repeat (40) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_outputs("midreset", 16'h0000, 4'b0000, 1'b0, 2'd0);
        check("midreset.mode_change", 32'(bus.mode_change), 32'd0);
        run_frame(4'b0000, 0, 0, mc);
        check("midreset.f1.mc", 32'(mc), 32'd0);
        check("midreset.f1.pixel", 32'(bus.pixel_data), 32'h0000);
        run_frame(4'b0000, 0, 0, mc);
        check("midreset.f2.mc", 32'(mc), 32'd1);
        check("midreset.f2.pixel", 32'(bus.pixel_data), 32'h0000);
        check("midreset.f2.enable", 32'(bus.ch_enable), 32'b0001);
        run_frame(4'b0000, 0, 0, mc);
        check("midreset.f3.mc", 32'(mc), 32'd0);
        check("midreset.f3.pixel", 32'(bus.pixel_data), 32'h1111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
